mole_arena: RTL and testbench

//  Parametrised whack-a-mole game core: N moles, one lit at a time, chosen by an LFSR.

---
 rtl/mole_arena_pkg.sv | 30 +++
 rtl/mole_arena_lfsr_rng.sv | 39 +++
 rtl/mole_arena.sv | 171 +++++++++++++++++
 tb/tb_mole_arena.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mole_arena_pkg.sv
// rtl/mole_arena_pkg.sv - shared types and helpers for the whack-a-mole core
package mole_arena_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_e;

    // XNOR-feedback left shift over the low w bits; the all-ones value locks up
    function automatic logic [63:0] next_lfsr(input logic [63:0] q, input int unsigned w);
        logic [63:0] taps;
        logic [63:0] mask;
        logic        fb;
        taps = (q >> (w - 1)) ^ (q >> (w - 2));
        fb   = ~taps[0];
        mask = (64'd1 << w) - 64'd1;
        return ((q << 1) | {63'd0, fb}) & mask;
    endfunction

    // Scale a w-bit random value onto 0..n-1 without a divider
    function automatic int unsigned pick_idx(input logic [63:0] lfsr, input int unsigned n,
                                             input int unsigned w);
        logic [63:0] prod;
        prod = lfsr * 64'(n);
        return 32'(prod >> w);
    endfunction

endpackage

// File: rtl/mole_arena_lfsr_rng.sv
// rtl/mole_arena_lfsr_rng.sv - loadable, gated XNOR LFSR used to choose the next mole
module lfsr_rng
    import mole_arena_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Reload has priority over stepping so IDLE always restarts the same sequence
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = SEED;
        end else if (enable) begin
            q_d = W'(next_lfsr(64'(q_q), W));
        end
    end

    // Generator register
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mole_arena.sv
// rtl/mole_arena.sv - whack-a-mole game core: FSM, visibility counter, score and misses
module mole_arena
    import mole_arena_pkg::*;
#(
    parameter int NUM_MOLES  = 3,
    parameter int SPEED_W    = 28,
    parameter int SCORE_W    = 8,
    parameter int LFSR_W     = 8,
    parameter int LFSR_SEED  = 0,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_MISSES = 3,
    localparam int MISS_W    = $clog2(MAX_MISSES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 game,
    input  logic [SPEED_W-1:0]   speed,
    input  logic [NUM_MOLES-1:0] button,
    output logic [NUM_MOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [MISS_W-1:0]    misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 game_over
);

    localparam logic [SPEED_W-1:0] GAP_LOAD  = SPEED_W'(GAP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e               state_q, state_d;
    logic [SPEED_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MOLES-1:0] mole_q, mole_d;
    logic [NUM_MOLES-1:0] btn_prev_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [MISS_W-1:0]    misses_q, misses_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [LFSR_W-1:0]    lfsr_q;

    logic [NUM_MOLES-1:0] press;
    logic                 hit, any_press, cnt_zero, last_miss;
    logic [SPEED_W-1:0]   show_load;
    int unsigned          idx;

    assign press     = button & ~btn_prev_q;
    assign hit       = |(press & mole_q);
    assign any_press = |press;
    assign cnt_zero  = (cnt_q == '0);
    assign last_miss = (misses_q == MISS_W'(MAX_MISSES - 1));
    assign show_load = (speed == '0) ? '0 : speed - SPEED_W'(1);
    assign idx       = pick_idx(64'(lfsr_q), NUM_MOLES, LFSR_W);

    lfsr_rng #(
        .W    (LFSR_W),
        .SEED (LFSR_W'(LFSR_SEED))
    ) u_rng (
        .clock  (clock),
        .reset  (reset),
        .load   (state_q == IDLE),
        .enable (state_q == GAP || state_q == SHOW),
        .q      (lfsr_q)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort wins, then hit beats timeout in SHOW
    always_comb begin
        state_d = state_q;
        if (!game) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = GAP;
                GAP:  if (cnt_zero) state_d = SHOW;
                SHOW: begin
                    if (hit) begin
                        state_d = GAP;
                    end else if (cnt_zero) begin
                        state_d = last_miss ? OVER : GAP;
                    end
                end
                default: state_d = OVER;
            endcase
        end
    end

    // Datapath next values; a wrong press on the final lit cycle is penalised and still times out
    always_comb begin
        cnt_d    = cnt_q;
        mole_d   = mole_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        if (!game) begin
            mole_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mole_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                    cnt_d    = GAP_LOAD;
                end
                GAP: begin
                    if (cnt_zero) begin
                        mole_d = NUM_MOLES'(1) << idx;
                        cnt_d  = show_load;
                    end else begin
                        cnt_d = cnt_q - SPEED_W'(1);
                    end
                end
                SHOW: begin
                    if (hit) begin
                        if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                        hit_d  = 1'b1;
                        mole_d = '0;
                        cnt_d  = GAP_LOAD;
                    end else begin
                        if (any_press && score_q != '0) score_d = score_q - SCORE_W'(1);
                        if (cnt_zero) begin
                            misses_d = misses_q + MISS_W'(1);
                            miss_d   = 1'b1;
                            mole_d   = '0;
                            cnt_d    = GAP_LOAD;
                        end else begin
                            cnt_d = cnt_q - SPEED_W'(1);
                        end
                    end
                end
                default: mole_d = '0;
            endcase
        end
    end

    // Datapath registers and button history
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            mole_q     <= '0;
            btn_prev_q <= '0;
            score_q    <= '0;
            misses_q   <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mole_q     <= mole_d;
            btn_prev_q <= button;
            score_q    <= score_d;
            misses_q   <= misses_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign mole       = mole_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_mole_arena.sv
// tb/tb_mole_arena.sv - directed self-checking bench for mole_arena
module tb_mole_arena;

    localparam int N   = 3;
    localparam int SW  = 28;
    localparam int SCW = 4;
    localparam int MW  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          game;
    logic [SW-1:0] speed;
    logic [N-1:0]  button;
    logic [N-1:0]  mole;
    logic [SCW-1:0] score;
    logic [MW-1:0] misses;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          game_over;

    int total = 0;
    int bad   = 0;
    int n;
    int dark;

    mole_arena #(
        .NUM_MOLES  (N),
        .SPEED_W    (SW),
        .SCORE_W    (SCW),
        .LFSR_W     (8),
        .LFSR_SEED  (0),
        .GAP_CYCLES (4),
        .MAX_MISSES (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .game       (game),
        .speed      (speed),
        .button     (button),
        .mole       (mole),
        .score      (score),
        .misses     (misses),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_lit();
        int k;
        k = 0;
        while (mole == '0 && k < 100) begin
            k++;
            tick();
        end
        check_val("wait_lit", 32'(mole != '0), 32'd1);
    endtask

    task automatic wait_dark(output int k);
        k = 0;
        while (mole != '0 && k < 100) begin
            k++;
            tick();
        end
        check_val("wait_dark", 32'(mole == '0), 32'd1);
    endtask

    function automatic logic [N-1:0] one_wrong(input logic [N-1:0] m);
        logic [N-1:0] w;
        w = ~m;
        return w & (~w + N'(1));
    endfunction

    initial begin
        reset  = 1'b1;
        game   = 1'b0;
        speed  = SW'(10);
        button = '0;
        tick();
        tick();
        check_val("rst_mole", 32'(mole), 32'd0);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_misses", 32'(misses), 32'd0);
        check_val("rst_over", 32'(game_over), 32'd0);
        check_val("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
        check_val("rst_lfsr", 32'(dut.u_rng.q), 32'd0);
        reset = 1'b0;

        // first mole: 4 dark cycles, lfsr=7 -> idx 0, 10 lit cycles, timeout
        game = 1'b1;
        tick();
        dark = 0;
        while (mole == '0 && dark < 50) begin
            dark++;
            tick();
        end
        check_val("gap_len", 32'(dark), 32'd4);
        check_val("first_mole", 32'(mole), 32'd1);
        wait_dark(n);
        check_val("lit_len", 32'(n), 32'd10);
        check_val("miss_pulse", 32'(miss_pulse), 32'd1);
        check_val("misses_1", 32'(misses), 32'd1);
        tick();
        check_val("miss_pulse_w", 32'(miss_pulse), 32'd0);

        // hit on the 3rd lit cycle, then exactly 4 dark cycles
        wait_lit();
        tick();
        tick();
        button = mole;
        tick();
        button = '0;
        check_val("hit_mole", 32'(mole), 32'd0);
        check_val("hit_score", 32'(score), 32'd1);
        check_val("hit_pulse", 32'(hit_pulse), 32'd1);
        dark = 0;
        while (mole == '0 && dark < 50) begin
            dark++;
            tick();
            if (dark == 1) check_val("hit_pulse_w", 32'(hit_pulse), 32'd0);
        end
        check_val("gap_after_hit", 32'(dark), 32'd4);

        // wrong presses: decrement, floor at 0, then rescore
        button = one_wrong(mole);
        tick();
        check_val("wrong_dec", 32'(score), 32'd0);
        button = '0;
        tick();
        button = one_wrong(mole);
        tick();
        check_val("wrong_floor", 32'(score), 32'd0);
        button = '0;
        tick();
        button = mole;
        tick();
        button = '0;
        check_val("rehit", 32'(score), 32'd1);
        wait_lit();
        button = mole;
        tick();
        button = '0;
        check_val("score_2", 32'(score), 32'd2);
        wait_lit();
        button = ~mole;
        tick();
        check_val("two_wrong", 32'(score), 32'd1);
        check_val("wrong_stays", 32'(mole != '0), 32'd1);
        button = '0;
        tick();
        button = mole;
        tick();
        check_val("score_back2", 32'(score), 32'd2);

        // held buttons are not presses
        button = '1;
        wait_lit();
        tick();
        tick();
        check_val("hold_noscore", 32'(score), 32'd2);
        check_val("hold_lit", 32'(mole != '0), 32'd1);
        wait_dark(n);
        check_val("misses_2", 32'(misses), 32'd2);
        button = '0;

        // third timeout ends the round
        wait_lit();
        wait_dark(n);
        check_val("over", 32'(game_over), 32'd1);
        check_val("over_score", 32'(score), 32'd2);
        check_val("over_misses", 32'(misses), 32'd3);
        repeat (3) tick();
        check_val("over_hold", 32'(game_over), 32'd1);
        check_val("over_dark", 32'(mole), 32'd0);
        button = '1;
        tick();
        check_val("over_press", 32'(score), 32'd2);
        button = '0;
        game = 1'b0;
        tick();
        check_val("idle_over", 32'(game_over), 32'd0);
        check_val("idle_score", 32'(score), 32'd2);
        check_val("idle_misses", 32'(misses), 32'd3);
        game = 1'b1;
        tick();
        check_val("new_score", 32'(score), 32'd0);
        check_val("new_misses", 32'(misses), 32'd0);

        // saturation at 15 after 16 hits
        repeat (16) begin
            wait_lit();
            button = mole;
            tick();
            button = '0;
        end
        check_val("saturate", 32'(score), 32'd15);

        // speed 0 behaves as 1
        speed = '0;
        wait_lit();
        wait_dark(n);
        check_val("speed0_len", 32'(n), 32'd1);
        check_val("speed0_miss", 32'(misses), 32'd1);

        // abort mid-SHOW
        speed = SW'(10);
        wait_lit();
        tick();
        tick();
        game = 1'b0;
        tick();
        check_val("abort_mole", 32'(mole), 32'd0);
        check_val("abort_score", 32'(score), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
